// File: rtl/gerador_interrupcao_pkg.sv
// gerador_interrupcao_pkg
// Shared definitions for the interrupt generator.
// Contents: configuration address codes, interrupt source indices, FSM state
// encoding, and helpers for priority selection and one-hot decoding.
package gerador_interrupcao_pkg;

  typedef logic [1:0] cfg_addr_t;
  typedef logic [1:0] src_idx_t;
  typedef logic [1:0] state_t;

  // Configuration register map
  localparam cfg_addr_t QUANTUM  = 2'b00;
  localparam cfg_addr_t CONTROL  = 2'b01;
  localparam cfg_addr_t PEND_CLR = 2'b10;

  // Bit positions in the pending vector and in the request-line vector
  localparam src_idx_t FIN = 2'd0;
  localparam src_idx_t CLK = 2'd1;
  localparam src_idx_t PRT = 2'd2;

  localparam state_t IDLE    = 2'd0;
  localparam state_t REQUEST = 2'd1;
  localparam state_t SERVICE = 2'd2;

  // Fixed priority: finish > clock > print.
  // Callers only use the result when pend is non-zero.
  function automatic src_idx_t fonte_prioritaria(input logic [2:0] pend);
    if (pend[FIN]) return FIN;
    if (pend[CLK]) return CLK;
    return PRT;
  endfunction

  function automatic logic [2:0] fonte_onehot(input src_idx_t src);
    return 3'b001 << src;
  endfunction

endpackage

// File: rtl/gerador_interrupcao_temporizador_quantum.sv
// temporizador_quantum
// Programmable time-slice timer. A quantum register feeds a down-counter.
// When the counter reaches 1, it reloads to the quantum value and o_tick is
// high for that cycle. A quantum of 0 stops the timer and holds the counter
// at 0.
// Ports:
//   clock      system clock; all state changes on the rising edge
//   reset_n    synchronous, active-low reset; loads RESET_QUANTUM
//   i_load     load strobe; writes i_quantum to both quantum and counter
//   i_quantum  new quantum value
//   o_tick     one-cycle event marking the end of each quantum period
module temporizador_quantum #(
  parameter int unsigned                  TIMER_WIDTH   = 32,
  parameter logic [TIMER_WIDTH-1:0]       RESET_QUANTUM = '0
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   i_load,
  input  logic [TIMER_WIDTH-1:0] i_quantum,
  output logic                   o_tick
);

  localparam logic [TIMER_WIDTH-1:0] ONE = TIMER_WIDTH'(1);

  logic [TIMER_WIDTH-1:0] r_quantum;
  logic [TIMER_WIDTH-1:0] r_counter;
  logic                   w_running;
  logic                   w_terminal;

  assign w_running  = (r_quantum != '0);
  assign w_terminal = (r_counter == ONE);
  // Reloading at 1 rather than at 0 makes the period exactly r_quantum
  // cycles, so a quantum of 1 ticks every cycle.
  assign o_tick     = w_running && w_terminal;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_quantum <= RESET_QUANTUM;
      r_counter <= RESET_QUANTUM;
    end else if (i_load) begin
      r_quantum <= i_quantum;
      r_counter <= i_quantum;
    end else if (!w_running) begin
      r_counter <= '0;
    end else if (w_terminal) begin
      r_counter <= r_quantum;
    end else begin
      r_counter <= r_counter - ONE;
    end
  end

endmodule

// File: rtl/gerador_interrupcao.sv
// gerador_interrupcao
// Interrupt source and arbiter. It collects finish, timer and print events
// into sticky pending bits. When global interrupts are enabled, it raises one
// request line at a time toward the vector selector. It then tracks the
// request / acknowledge / return handshake with the CPU and saves the return
// PC.
// Ports:
//   clock, reset_n          system clock; synchronous active-low reset
//   finish_event            one-cycle pulse; sets pending.finish
//   print_event             one-cycle pulse; sets pending.print
//   cfg_write/cfg_addr      configuration write strobe and register select
//   w_data                  write data (quantum, GIE in bit 0, w1c mask [2:0])
//   int_ack                 CPU has jumped to the ISR
//   int_return              CPU executes return-from-interrupt
//   inNextPcAddr            PC to be saved on acknowledge
//   FinishInterrupt, ClockInterrupt, PrintInterruption
//                           registered request lines; at most one is high
//   outEpc                  saved return PC
//   outInService            high while an ISR is running
//
// state   | meaning
// IDLE    | no interrupt outstanding; arbitrates pending sources when GIE=1
// REQUEST | request line for r_sel is high; waiting for int_ack
// SERVICE | ISR running; all request lines low; waiting for int_return
module gerador_interrupcao
  import gerador_interrupcao_pkg::*;
#(
  parameter int unsigned            TIMER_WIDTH   = 32,
  parameter logic [TIMER_WIDTH-1:0] RESET_QUANTUM = '0
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        finish_event,
  input  logic        print_event,
  input  logic        cfg_write,
  input  logic [1:0]  cfg_addr,
  input  logic [31:0] w_data,
  input  logic        int_ack,
  input  logic        int_return,
  input  logic [31:0] inNextPcAddr,
  output logic        FinishInterrupt,
  output logic        ClockInterrupt,
  output logic        PrintInterruption,
  output logic [31:0] outEpc,
  output logic        outInService
);

  state_t      r_state;
  src_idx_t    r_sel;
  logic [2:0]  r_pending;
  logic [2:0]  r_lines;
  logic        r_gie;
  logic        r_in_service;
  logic [31:0] r_epc;

  logic        w_tick;
  logic        w_quantum_wr;
  logic        w_control_wr;
  logic        w_clear_wr;
  logic        w_ack_ok;
  logic [2:0]  w_set;
  logic [2:0]  w_clr;
  logic [2:0]  w_pending_next;
  src_idx_t    w_sel_next;

  assign w_quantum_wr = cfg_write && (cfg_addr == QUANTUM);
  assign w_control_wr = cfg_write && (cfg_addr == CONTROL);
  assign w_clear_wr   = cfg_write && (cfg_addr == PEND_CLR);

  temporizador_quantum #(
    .TIMER_WIDTH   (TIMER_WIDTH),
    .RESET_QUANTUM (RESET_QUANTUM)
  ) u_temporizador (
    .clock     (clock),
    .reset_n   (reset_n),
    .i_load    (w_quantum_wr),
    .i_quantum (w_data[TIMER_WIDTH-1:0]),
    .o_tick    (w_tick)
  );

  assign w_ack_ok = (r_state == REQUEST) && int_ack;

  // Bit order matches FIN/CLK/PRT: finish in bit 0, clock in bit 1, print in bit 2.
  assign w_set = {print_event, w_tick, finish_event};
  assign w_clr = (w_clear_wr ? w_data[2:0] : 3'b000)
               | (w_ack_ok   ? fonte_onehot(r_sel) : 3'b000);
  // Applying the set after the clear means a new event in the same cycle
  // as a clear is never lost.
  assign w_pending_next = (r_pending & ~w_clr) | w_set;

  assign w_sel_next = fonte_prioritaria(r_pending);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_sel        <= FIN;
      r_pending    <= 3'b000;
      r_lines      <= 3'b000;
      r_gie        <= 1'b0;
      r_in_service <= 1'b0;
      r_epc        <= 32'h0;
    end else begin
      r_pending <= w_pending_next;
      if (w_control_wr) begin
        r_gie <= w_data[0];
      end
      case (r_state)
        IDLE: begin
          if (r_gie && (r_pending != 3'b000)) begin
            r_sel   <= w_sel_next;
            r_lines <= fonte_onehot(w_sel_next);
            r_state <= REQUEST;
          end
        end
        // Only int_ack leaves REQUEST. Clearing GIE or the source's pending
        // bit here does not withdraw the line, so the CPU never sees a
        // request disappear before it acknowledges it.
        REQUEST: begin
          if (int_ack) begin
            r_lines      <= 3'b000;
            r_epc        <= inNextPcAddr;
            r_in_service <= 1'b1;
            r_state      <= SERVICE;
          end
        end
        SERVICE: begin
          if (int_return) begin
            r_in_service <= 1'b0;
            r_state      <= IDLE;
          end
        end
        default: begin
          r_lines      <= 3'b000;
          r_in_service <= 1'b0;
          r_state      <= IDLE;
        end
      endcase
    end
  end

  assign FinishInterrupt   = r_lines[FIN];
  assign ClockInterrupt    = r_lines[CLK];
  assign PrintInterruption = r_lines[PRT];
  assign outEpc            = r_epc;
  assign outInService      = r_in_service;

endmodule

// File: tb/tb_gerador_interrupcao.sv
// Self-checking bench for gerador_interrupcao: directed scenarios followed by
// randomized traffic. All checks compare against a behavioural model kept in
// this file.
module tb_gerador_interrupcao;

  localparam int          TW = 32;
  localparam logic [31:0] RQ = 32'd7;

  logic        clock = 1'b0;
  logic        reset_n, finish_event, print_event, cfg_write, int_ack, int_return;
  logic [1:0]  cfg_addr;
  logic [31:0] w_data, inNextPcAddr, outEpc;
  logic        FinishInterrupt, ClockInterrupt, PrintInterruption, outInService;

  int n_vet  = 0;
  int n_erro = 0;

  always #5 clock = ~clock;

  gerador_interrupcao #(.TIMER_WIDTH(TW), .RESET_QUANTUM(RQ)) dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .finish_event      (finish_event),
    .print_event       (print_event),
    .cfg_write         (cfg_write),
    .cfg_addr          (cfg_addr),
    .w_data            (w_data),
    .int_ack           (int_ack),
    .int_return        (int_return),
    .inNextPcAddr      (inNextPcAddr),
    .FinishInterrupt   (FinishInterrupt),
    .ClockInterrupt    (ClockInterrupt),
    .PrintInterruption (PrintInterruption),
    .outEpc            (outEpc),
    .outInService      (outInService)
  );

  // Behavioural model. The timer is tracked as an arithmetic schedule: after
  // a load at edge m_load with quantum m_q, ticks occur at m_load + k*m_q.
  // m_estado: 0 = idle, 1 = request line up, 2 = in service.
  bit [2:0]    m_pend;
  bit          m_gie;
  int          m_estado;
  int          m_sel;
  bit [31:0]   m_epc;
  longint      m_q;
  longint      m_load;
  longint      borda = 0;
  logic [31:0] pc_atual = 32'h0;

  task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    n_vet++;
    if (obs !== esp) begin
      n_erro++;
      $display("FAIL %s: observed %h expected %h (edge %0d)", tag, obs, esp, borda);
    end
  endtask

  task automatic modelo_borda();
    bit       tick;
    bit [2:0] set, clr;
    borda++;
    if (!reset_n) begin
      m_pend = 0; m_gie = 0; m_estado = 0; m_sel = 0; m_epc = 0;
      m_q = longint'(RQ); m_load = borda;
      return;
    end
    tick = (m_q != 0) && (borda > m_load) && (((borda - m_load) % m_q) == 0);
    set  = {print_event, tick, finish_event};
    clr  = 3'b000;
    if (cfg_write && cfg_addr == 2'b10) clr = clr | w_data[2:0];
    case (m_estado)
      0: if (m_gie && m_pend != 0) begin
           for (int s = 2; s >= 0; s--) if (m_pend[s]) m_sel = s;
           m_estado = 1;
         end
      1: if (int_ack) begin
           clr[m_sel] = 1'b1;
           m_epc = inNextPcAddr;
           m_estado = 2;
         end
      default: if (int_return) m_estado = 0;
    endcase
    m_pend = (m_pend & ~clr) | set;
    if (cfg_write && cfg_addr == 2'b01) m_gie = w_data[0];
    if (cfg_write && cfg_addr == 2'b00) begin
      m_q = longint'(w_data);
      m_load = borda;
    end
  endtask

  // Drive inputs for one cycle, advance the model on the rising edge, and
  // compare all outputs on the falling edge.
  task automatic ciclo(input bit rst, input bit fin, input bit prt, input bit ack,
                       input bit ret, input bit wr, input bit [1:0] ad, input bit [31:0] wd);
    bit [2:0] l;
    reset_n = rst; finish_event = fin; print_event = prt;
    int_ack = ack; int_return = ret;
    cfg_write = wr; cfg_addr = ad; w_data = wd;
    inNextPcAddr = pc_atual;
    @(posedge clock);
    #1;
    modelo_borda();
    @(negedge clock);
    l = (m_estado == 1) ? (3'b001 << m_sel) : 3'b000;
    verifica("FinishInterrupt",   32'(FinishInterrupt),   32'(l[0]));
    verifica("ClockInterrupt",    32'(ClockInterrupt),    32'(l[1]));
    verifica("PrintInterruption", 32'(PrintInterruption), 32'(l[2]));
    verifica("outEpc",            outEpc,                 m_epc);
    verifica("outInService",      32'(outInService),      32'(m_estado == 2));
  endtask

  task automatic ocioso();
    ciclo(1, 0, 0, 0, 0, 0, 2'b00, 32'h0);
  endtask

  task automatic escreve(input bit [1:0] ad, input bit [31:0] wd);
    ciclo(1, 0, 0, 0, 0, 1, ad, wd);
  endtask

  // Stop the timer, mask interrupts, finish any handshake in progress, and
  // clear all pending bits.
  task automatic drena();
    escreve(2'b00, 32'h0);
    escreve(2'b01, 32'h0);
    for (int i = 0; i < 8; i++) ciclo(1, 0, 0, m_estado == 1, m_estado == 2, 0, 2'b00, 32'h0);
    escreve(2'b10, 32'h7);
  endtask

  initial begin
    longint subidas[$];
    bit     ant;
    int     k;
    int     n;
    bit     rst, fin, prt, ack, ret, wr;
    bit [1:0]  ad;
    bit [31:0] wd;

    // Reset
    ciclo(0, 0, 0, 0, 0, 0, 2'b00, 32'h0);
    ciclo(0, 1, 1, 0, 0, 0, 2'b00, 32'h0);
    verifica("rst_epc", outEpc, 32'h0);
    verifica("rst_linhas", 32'({FinishInterrupt, ClockInterrupt, PrintInterruption}), 32'h0);

    // Timer period: quantum 5, ack one cycle after request, return later
    pc_atual = 32'h0000_0040;
    escreve(2'b00, 32'd5);
    escreve(2'b01, 32'd1);
    k = 0; ant = 0;
    for (int i = 0; i < 40; i++) begin
      ciclo(1, 0, 0, m_estado == 1, (m_estado == 2) && (k == 3), 0, 2'b00, 32'h0);
      k = (m_estado == 2) ? k + 1 : 0;
      if (ClockInterrupt && !ant) subidas.push_back(borda);
      ant = ClockInterrupt;
    end
    verifica("n_pedidos_clk", 32'(subidas.size() >= 5), 32'd1);
    for (int j = 2; j < subidas.size(); j++)
      verifica("periodo_clk", 32'(subidas[j] - subidas[j-1]), 32'd5);
    verifica("epc_0x40", outEpc, 32'h0000_0040);

    // Priority: finish and timer tick on the same edge
    pc_atual = 32'h0000_1000;
    drena();
    escreve(2'b00, 32'd6);
    escreve(2'b01, 32'd1);
    for (int i = 0; i < 10 && (((borda + 1 - m_load) % m_q) != 0); i++) ocioso();
    ciclo(1, 1, 0, 0, 0, 0, 2'b00, 32'h0);
    ocioso();
    verifica("prio_fin", 32'(FinishInterrupt), 32'd1);
    verifica("prio_clk_espera", 32'(ClockInterrupt), 32'd0);
    ciclo(1, 0, 0, 1, 0, 0, 2'b00, 32'h0);
    ocioso();
    ciclo(1, 0, 0, 0, 1, 0, 2'b00, 32'h0);
    verifica("ret_r1_clk", 32'(ClockInterrupt), 32'd0);
    ocioso();
    verifica("ret_r2_clk", 32'(ClockInterrupt), 32'd1);

    // Masking, then enabling GIE
    drena();
    ciclo(1, 0, 0, 1, 0, 0, 2'b00, 32'h0);
    verifica("ack_espurio", 32'(outInService), 32'd0);
    ciclo(1, 0, 1, 0, 0, 0, 2'b00, 32'h0);
    ocioso(); ocioso(); ocioso();
    verifica("mascara_prt", 32'(PrintInterruption), 32'd0);
    escreve(2'b01, 32'd1);
    verifica("gie_borda1", 32'(PrintInterruption), 32'd0);
    ocioso();
    verifica("gie_borda2", 32'(PrintInterruption), 32'd1);

    // Nesting is blocked while in service
    ciclo(1, 0, 0, 1, 0, 0, 2'b00, 32'h0);
    ciclo(1, 0, 1, 0, 0, 0, 2'b00, 32'h0);
    ocioso(); ocioso(); ocioso();
    verifica("aninhado_prt", 32'(PrintInterruption), 32'd0);
    verifica("aninhado_serv", 32'(outInService), 32'd1);
    ciclo(1, 0, 0, 0, 1, 0, 2'b00, 32'h0);
    ocioso();
    verifica("apos_ret_prt", 32'(PrintInterruption), 32'd1);

    // A set in the same cycle as its w1c clear wins
    drena();
    ciclo(1, 0, 1, 0, 0, 1, 2'b10, 32'h4);
    escreve(2'b01, 32'd1);
    ocioso();
    verifica("corrida_w1c", 32'(PrintInterruption), 32'd1);

    // Reset while in service, then timer restarts from RESET_QUANTUM
    ciclo(1, 0, 0, 1, 0, 0, 2'b00, 32'h0);
    verifica("pre_rst_serv", 32'(outInService), 32'd1);
    ciclo(0, 0, 0, 0, 0, 0, 2'b00, 32'h0);
    verifica("rst_serv", 32'(outInService), 32'd0);
    verifica("rst_epc2", outEpc, 32'h0);
    escreve(2'b01, 32'd1);
    n = 0;
    for (int i = 1; i <= 15 && n == 0; i++) begin
      ocioso();
      if (ClockInterrupt) n = i;
    end
    verifica("rst_quantum", 32'(n), 32'd7);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(199) != 0);
      fin = ($urandom_range(9) == 0);
      prt = ($urandom_range(9) == 0);
      ack = (m_estado == 1) ? ($urandom_range(2) == 0) : ($urandom_range(19) == 0);
      ret = (m_estado == 2) ? ($urandom_range(3) == 0) : ($urandom_range(19) == 0);
      wr  = ($urandom_range(11) == 0);
      ad  = 2'($urandom_range(3));
      if (ad == 2'b00)      wd = 32'($urandom_range(9));
      else if (ad == 2'b01) wd = 32'($urandom_range(3) != 0);
      else                  wd = $urandom;
      pc_atual = $urandom;
      ciclo(rst, fin, prt, ack, ret, wr, ad, wd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vet, n_erro);
    $finish;
  end

endmodule
